// File: rtl/alu_pkg.sv
// Shared definitions for the ALU dispatch stage: widths, opcodes, error codes, FSM states.
package alu_pkg;

  localparam int DATA_W = 72;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_MUL  = 4'd2;
  localparam logic [3:0] OP_DIV  = 4'd3;
  localparam logic [3:0] OP_AND  = 4'd4;
  localparam logic [3:0] OP_OR   = 4'd5;
  localparam logic [3:0] OP_ADDI = 4'd6;
  localparam logic [3:0] OP_ANDI = 4'd7;
  localparam logic [3:0] OP_ORI  = 4'd8;
  localparam logic [3:0] OP_XOR  = 4'd9;
  localparam logic [3:0] OP_SHL  = 4'd10;
  localparam logic [3:0] OP_SHR  = 4'd11;
  localparam logic [3:0] OP_BEQ  = 4'd12;
  localparam logic [3:0] OP_BNE  = 4'd13;
  localparam logic [3:0] OP_BLT  = 4'd14;
  localparam logic [3:0] OP_BGT  = 4'd15;

  localparam logic [1:0] ERR_OK   = 2'b00;
  localparam logic [1:0] ERR_DIV0 = 2'b01;
  localparam logic [1:0] ERR_TMO  = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  // Ops whose B operand comes from the sign-extended immediate field.
  function automatic logic is_imm_op(input logic [3:0] op);
    return (op == OP_ADDI) || (op == OP_ANDI) || (op == OP_ORI);
  endfunction

endpackage

// File: rtl/alu_operand_sel.sv
// Combinational B-operand select (register or sign-extended immediate) and divide-by-zero detect.
module alu_operand_sel
  import alu_pkg::*;
#(
  parameter int DATA_W = alu_pkg::DATA_W,
  parameter int IMM_W  = 18
) (
  input  logic [3:0]        op,
  input  logic [DATA_W-1:0] b,
  input  logic [IMM_W-1:0]  imm,
  output logic [DATA_W-1:0] b_sel,
  output logic              div0
);

  logic [DATA_W-1:0] imm_ext;

  // Sign-extend the immediate, pick the B source, and flag a zero divisor.
  always_comb begin
    imm_ext = {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm};
    b_sel   = is_imm_op(op) ? imm_ext : b;
    div0    = (op == OP_DIV) && (b == '0);
  end

endmodule

// File: rtl/alu_dispatch.sv
// Dispatch stage in front of the ALU: accepts one instruction, runs it on the ALU,
// and hands the result (or a div-zero / timeout error) to writeback.
//
//   state | meaning
//   IDLE  | ready for a new instruction (in_ready=1)
//   EXEC  | operands driven to the ALU, waiting for alu_done or timeout
//   RESP  | result presented on wb_*, waiting for wb_ready
module alu_dispatch
  import alu_pkg::*;
#(
  parameter int DATA_W  = alu_pkg::DATA_W,
  parameter int IMM_W   = 18,
  parameter int TIMEOUT = 64,
  parameter int TAG_W   = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_op,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  input  logic [IMM_W-1:0]  in_imm,
  input  logic [TAG_W-1:0]  in_tag,
  output logic [3:0]        alu_op,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  input  logic [DATA_W-1:0] alu_c,
  input  logic              alu_done,
  output logic              wb_valid,
  input  logic              wb_ready,
  output logic [DATA_W-1:0] wb_data,
  output logic [TAG_W-1:0]  wb_tag,
  output logic              wb_branch,
  output logic [1:0]        wb_err
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_t            state, state_nx;
  logic [CNT_W-1:0]  tmo_cnt, tmo_cnt_nx;
  logic [TAG_W-1:0]  tag_q, tag_nx;
  logic [3:0]        alu_op_nx;
  logic [DATA_W-1:0] alu_a_nx, alu_b_nx;
  logic              in_ready_nx, wb_valid_nx, wb_branch_nx;
  logic [DATA_W-1:0] wb_data_nx;
  logic [TAG_W-1:0]  wb_tag_nx;
  logic [1:0]        wb_err_nx;
  logic [DATA_W-1:0] b_sel;
  logic              div0;
  logic              accept;

  alu_operand_sel #(
    .DATA_W (DATA_W),
    .IMM_W  (IMM_W)
  ) u_operand_sel (
    .op    (in_op),
    .b     (in_b),
    .imm   (in_imm),
    .b_sel (b_sel),
    .div0  (div0)
  );

  assign accept = in_valid & in_ready;

  // Next-state and next-output logic; every register holds unless a transition updates it.
  always_comb begin
    state_nx     = state;
    tmo_cnt_nx   = tmo_cnt;
    tag_nx       = tag_q;
    alu_op_nx    = alu_op;
    alu_a_nx     = alu_a;
    alu_b_nx     = alu_b;
    wb_data_nx   = wb_data;
    wb_tag_nx    = wb_tag;
    wb_branch_nx = wb_branch;
    wb_err_nx    = wb_err;
    case (state)
      IDLE: begin
        if (accept) begin
          alu_op_nx  = in_op;
          alu_a_nx   = in_a;
          alu_b_nx   = b_sel;
          tag_nx     = in_tag;
          tmo_cnt_nx = '0;
          if (div0) begin
            // Zero divisor never reaches the ALU; answer straight away.
            state_nx     = RESP;
            wb_data_nx   = '1;
            wb_tag_nx    = in_tag;
            wb_err_nx    = ERR_DIV0;
            wb_branch_nx = 1'b0;
          end else begin
            state_nx = EXEC;
          end
        end
      end
      EXEC: begin
        if (alu_done) begin
          // Done beats the timeout when both land in the same cycle.
          state_nx     = RESP;
          wb_data_nx   = alu_c;
          wb_tag_nx    = tag_q;
          wb_err_nx    = ERR_OK;
          wb_branch_nx = (alu_op >= OP_BEQ) & alu_c[0];
        end else if (tmo_cnt == CNT_LAST) begin
          state_nx     = RESP;
          wb_data_nx   = '0;
          wb_tag_nx    = tag_q;
          wb_err_nx    = ERR_TMO;
          wb_branch_nx = 1'b0;
        end else begin
          tmo_cnt_nx = tmo_cnt + CNT_W'(1);
        end
      end
      RESP: begin
        if (wb_ready) begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
    in_ready_nx = (state_nx == IDLE);
    wb_valid_nx = (state_nx == RESP);
  end

  // State and registered outputs; reset aborts any in-flight instruction.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      tmo_cnt   <= '0;
      tag_q     <= '0;
      in_ready  <= 1'b0;
      alu_op    <= '0;
      alu_a     <= '0;
      alu_b     <= '0;
      wb_valid  <= 1'b0;
      wb_data   <= '0;
      wb_tag    <= '0;
      wb_branch <= 1'b0;
      wb_err    <= ERR_OK;
    end else begin
      state     <= state_nx;
      tmo_cnt   <= tmo_cnt_nx;
      tag_q     <= tag_nx;
      in_ready  <= in_ready_nx;
      alu_op    <= alu_op_nx;
      alu_a     <= alu_a_nx;
      alu_b     <= alu_b_nx;
      wb_valid  <= wb_valid_nx;
      wb_data   <= wb_data_nx;
      wb_tag    <= wb_tag_nx;
      wb_branch <= wb_branch_nx;
      wb_err    <= wb_err_nx;
    end
  end

endmodule

// File: tb/tb_alu_dispatch.sv
// Bench for alu_dispatch: directed instructions, a behavioural ALU/result model, and a
// per-cycle compare process, plus literal expectations on each transaction.
module tb_alu_dispatch;

  localparam int DW = 72;
  localparam int IW = 18;
  localparam int TMO = 64;
  localparam int TW = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [3:0]    in_op = '0;
  logic [DW-1:0] in_a = '0, in_b = '0;
  logic [IW-1:0] in_imm = '0;
  logic [TW-1:0] in_tag = '0;
  logic [3:0]    alu_op;
  logic [DW-1:0] alu_a, alu_b;
  logic [DW-1:0] alu_c = '0;
  logic          alu_done = 1'b0;
  logic          wb_valid;
  logic          wb_ready = 1'b0;
  logic [DW-1:0] wb_data;
  logic [TW-1:0] wb_tag;
  logic          wb_branch;
  logic [1:0]    wb_err;

  int n_chk = 0;
  int n_fail = 0;

  // model expectations for the instruction in flight
  logic [3:0]    exp_op;
  logic [DW-1:0] exp_a, exp_b, exp_data;
  logic [TW-1:0] exp_tag;
  logic          exp_br;
  logic [1:0]    exp_err;
  int            exp_lat;
  logic          busy = 1'b0, chk_alu = 1'b0, resp_ok = 1'b0;

  alu_dispatch #(.DATA_W(DW), .IMM_W(IW), .TIMEOUT(TMO), .TAG_W(TW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_a(in_a), .in_b(in_b), .in_imm(in_imm), .in_tag(in_tag), .alu_op(alu_op),
    .alu_a(alu_a), .alu_b(alu_b), .alu_c(alu_c), .alu_done(alu_done),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_data(wb_data), .wb_tag(wb_tag),
    .wb_branch(wb_branch), .wb_err(wb_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask

  // What the ALU would produce for an op; the dispatcher just forwards it.
  function automatic logic [DW-1:0] alu_fn(input logic [3:0] op, input logic [DW-1:0] a,
                                           input logic [DW-1:0] b);
    case (op)
      4'd0, 4'd6: return a + b;
      4'd1:       return a - b;
      4'd2:       return a * b;
      4'd3:       return (b == 0) ? '0 : a / b;
      4'd4, 4'd7: return a & b;
      4'd5, 4'd8: return a | b;
      4'd9:       return a ^ b;
      4'd10:      return a << b[6:0];
      4'd11:      return a >> b[6:0];
      4'd12:      return DW'(a == b);
      4'd13:      return DW'(a != b);
      4'd14:      return DW'($signed(a) < $signed(b));
      default:    return DW'($signed(a) > $signed(b));
    endcase
  endfunction

  task automatic check_reset();
    chk("rst_in_ready", DW'(in_ready), 0);
    chk("rst_wb_valid", DW'(wb_valid), 0);
    chk("rst_wb_data", wb_data, 0);
    chk("rst_wb_tag", DW'(wb_tag), 0);
    chk("rst_wb_branch", DW'(wb_branch), 0);
    chk("rst_wb_err", DW'(wb_err), 0);
    chk("rst_alu_op", DW'(alu_op), 0);
    chk("rst_alu_a", alu_a, 0);
    chk("rst_alu_b", alu_b, 0);
  endtask

  // dly: EXEC cycle (1-based) in which the ALU raises done; 0 = never.
  // bp: cycles of wb_ready=0 (with stale done pulses) before the result is taken.
  task automatic run(input logic [3:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b,
                     input logic [IW-1:0] imm, input logic [TW-1:0] tag, input int dly,
                     input int bp, output logic [DW-1:0] gd, output logic [1:0] ge,
                     output logic gb, output int glat);
    logic [DW-1:0] bx, c;
    int n;
    bx = (op == 4'd6 || op == 4'd7 || op == 4'd8) ? {{(DW-IW){imm[IW-1]}}, imm} : b;
    c = alu_fn(op, a, bx);
    exp_op = op; exp_a = a; exp_b = bx; exp_tag = tag;
    if (op == 4'd3 && b == 0) begin
      exp_data = '1; exp_err = 2'b01; exp_br = 1'b0; exp_lat = 1;
    end else if (dly >= 1 && dly <= TMO) begin
      exp_data = c; exp_err = 2'b00; exp_br = (op >= 4'd12) ? c[0] : 1'b0; exp_lat = dly + 1;
    end else begin
      exp_data = '0; exp_err = 2'b10; exp_br = 1'b0; exp_lat = TMO + 1;
    end
    in_op = op; in_a = a; in_b = b; in_imm = imm; in_tag = tag; in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 20) begin
      @(posedge clk); #1; n++;
    end
    chk("accept_ready", DW'(in_ready), 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_op = 4'($urandom); in_a = {$urandom, $urandom, $urandom}; in_b = '0; in_tag = '1;
    busy = 1'b1; chk_alu = 1'b1; resp_ok = 1'b1;
    glat = 1;
    while (!wb_valid && glat < 200) begin
      alu_done = (glat == dly);
      alu_c = (glat == dly) ? c : {$urandom, $urandom, $urandom};
      @(posedge clk); #1; glat++;
    end
    alu_done = 1'b0;
    chk("wb_latency", DW'(glat), DW'(exp_lat));
    gd = wb_data; ge = wb_err; gb = wb_branch;
    for (int i = 0; i < bp; i++) begin
      alu_done = 1'b1; alu_c = {$urandom, $urandom, $urandom};
      @(posedge clk); #1;
      chk("bp_wb_valid", DW'(wb_valid), 1);
    end
    alu_done = 1'b0;
    wb_ready = 1'b1;
    @(posedge clk); #1;
    wb_ready = 1'b0; busy = 1'b0; chk_alu = 1'b0; resp_ok = 1'b0;
    chk("post_wb_valid", DW'(wb_valid), 0);
    chk("post_in_ready", DW'(in_ready), 1);
  endtask

  // Compare DUT against the model on every falling edge while the outputs are meaningful.
  always @(negedge clk) begin
    if (!rst) begin
      if (busy) chk("busy_in_ready", DW'(in_ready), 0);
      if (chk_alu) begin
        chk("alu_op", DW'(alu_op), DW'(exp_op));
        chk("alu_a", alu_a, exp_a);
        chk("alu_b", alu_b, exp_b);
      end
      if (wb_valid) begin
        chk("wb_valid_expected", DW'(resp_ok), 1);
        if (resp_ok) begin
          chk("wb_data", wb_data, exp_data);
          chk("wb_tag", DW'(wb_tag), DW'(exp_tag));
          chk("wb_branch", DW'(wb_branch), DW'(exp_br));
          chk("wb_err", DW'(wb_err), DW'(exp_err));
        end
      end
    end
  end

  initial begin
    logic [DW-1:0] d;
    logic [1:0] e;
    logic b;
    int l, seen;

    repeat (2) @(posedge clk);
    #1;
    check_reset();
    rst = 1'b0;
    chk("release_in_ready_0", DW'(in_ready), 0);
    @(posedge clk); #1;
    chk("release_in_ready_1", DW'(in_ready), 1);

    // stale done in IDLE
    alu_done = 1'b1; alu_c = 72'd99;
    @(posedge clk); #1;
    alu_done = 1'b0;
    chk("idle_done_no_wb", DW'(wb_valid), 0);
    chk("idle_done_ready", DW'(in_ready), 1);

    run(4'd0, 72'd10, 72'd15, '0, 5'd3, 1, 0, d, e, b, l);
    chk("add_data", d, 72'd25); chk("add_err", DW'(e), 0); chk("add_lat", DW'(l), 2);

    run(4'd6, 72'd100, 72'd7, 18'h3FFFB, 5'd4, 2, 0, d, e, b, l);
    chk("addi_data", d, 72'd95);
    chk("addi_alu_b", alu_b, 72'hFFFFFFFFFFFFFFFFFB);

    run(4'd3, 72'd100, 72'd0, '0, 5'd5, 1, 0, d, e, b, l);
    chk("div0_data", d, {DW{1'b1}}); chk("div0_err", DW'(e), 1); chk("div0_lat", DW'(l), 1);

    run(4'd3, 72'd100, 72'd5, '0, 5'd6, 3, 0, d, e, b, l);
    chk("div_data", d, 72'd20); chk("div_err", DW'(e), 0);

    run(4'd12, 72'd50, 72'd50, '0, 5'd7, 1, 0, d, e, b, l);
    chk("beq_branch", DW'(b), 1);

    run(4'd13, 72'd50, 72'd50, '0, 5'd8, 1, 0, d, e, b, l);
    chk("bne_branch", DW'(b), 0);

    run(4'd0, 72'd1, 72'd2, '0, 5'd9, 0, 0, d, e, b, l);
    chk("tmo_data", d, 72'd0); chk("tmo_err", DW'(e), 2); chk("tmo_lat", DW'(l), 65);

    run(4'd0, 72'd7, 72'd8, '0, 5'd10, 64, 0, d, e, b, l);
    chk("late_done_data", d, 72'd15); chk("late_done_err", DW'(e), 0);
    chk("late_done_lat", DW'(l), 65);

    run(4'd1, 72'd30, 72'd12, '0, 5'd11, 1, 10, d, e, b, l);
    chk("bp_data", d, 72'd18);

    // reset while in EXEC
    chk("abort_pre_ready", DW'(in_ready), 1);
    in_op = 4'd2; in_a = 72'd6; in_b = 72'd7; in_tag = 5'd12; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("abort_in_ready", DW'(in_ready), 1);
    alu_done = 1'b1; alu_c = 72'd42;
    @(posedge clk); #1;
    alu_done = 1'b0;
    seen = 0;
    repeat (80) begin
      @(posedge clk); #1;
      if (wb_valid) seen++;
    end
    chk("abort_no_wb", DW'(seen), 0);

    run(4'd5, 72'hF0, 72'h0F, '0, 5'd13, 1, 0, d, e, b, l);
    chk("or_data", d, 72'hFF); chk("or_tag_lat", DW'(l), 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
